// File: rtl/regfile_mp_if.sv
// Bundle of read, write, issue and scoreboard signals between the core and regfile_mp.
`timescale 1ns/1ps
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [XLEN-1:0]  rdata1;
  logic [XLEN-1:0]  rdata2;
  logic             busy1;
  logic             busy2;
  logic             wen0;
  logic [AW-1:0]    waddr0;
  logic [XLEN-1:0]  wdata0;
  logic             wen1;
  logic [AW-1:0]    waddr1;
  logic [XLEN-1:0]  wdata1;
  logic             issue_en;
  logic [AW-1:0]    issue_rd;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output rs1, rs2, wen0, waddr0, wdata0, wen1, waddr1, wdata1, issue_en, issue_rd,
    input  rdata1, rdata2, busy1, busy2, busy_vec
  );

  modport slave (
    input  rs1, rs2, wen0, waddr0, wdata0, wen1, waddr1, wdata1, issue_en, issue_rd,
    output rdata1, rdata2, busy1, busy2, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-read / two-write RV32 integer register file with per-register busy scoreboard; x0 reads 0.
// Optional same-cycle write forwarding on the read ports when REGFILE_BYPASS_EN is defined.
`timescale 1ns/1ps
module regfile_mp_param_chk #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) ();
  if ((NREGS != (1 << AW)) || (NREGS < 2) || (NREGS > 64)) begin : g_bad_params
    $error("regfile_mp: NREGS must be a power of two in 2..64 equal to 2**AW");
  end
endmodule

module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input logic         clk,
  input logic         reset_n,
  regfile_mp_if.slave rf
);

  regfile_mp_param_chk #(.NREGS(NREGS), .AW(AW)) u_param_chk ();

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [NREGS-1:0] we0_s;
  logic [NREGS-1:0] we1_s;
  logic [NREGS-1:0] set_s;
  logic [XLEN:0]    rd1_s;
  logic [XLEN:0]    rd2_s;

`ifdef REGFILE_BYPASS_EN
  // Forward same-cycle write data to one read port; the load port outranks the ALU port.
  function automatic logic [XLEN:0] fwd_read(
    input logic [AW-1:0]   rs,
    input logic [XLEN:0]   arr,
    input logic            en,
    input logic            w1,
    input logic [AW-1:0]   a1,
    input logic [XLEN-1:0] d1,
    input logic            w0,
    input logic [AW-1:0]   a0,
    input logic [XLEN-1:0] d0
  );
    logic [XLEN:0] res;
    if (en && (rs != {AW{1'b0}}) && w1 && (a1 == rs)) begin
      res = {1'b0, d1};
    end else if (en && (rs != {AW{1'b0}}) && w0 && (a0 == rs)) begin
      res = {1'b0, d0};
    end else begin
      res = arr;
    end
    return res;
  endfunction
`endif

  // Per-register write strobes; port 0 is masked wherever port 1 hits the same register.
  always_comb begin
    we0_s = {NREGS{1'b0}};
    we1_s = {NREGS{1'b0}};
    set_s = {NREGS{1'b0}};
    for (int r = 1; r < NREGS; r++) begin
      we1_s[r] = rf.wen1 && (rf.waddr1 == AW'(r));
      we0_s[r] = rf.wen0 && (rf.waddr0 == AW'(r)) && !we1_s[r];
      set_s[r] = rf.issue_en && (rf.issue_rd == AW'(r));
    end
  end

  // Scoreboard next state: issue sets, any write clears, set outranks clear.
  always_comb begin
    busy_nxt_s = {NREGS{1'b0}};
    for (int r = 1; r < NREGS; r++) begin
      if (set_s[r]) begin
        busy_nxt_s[r] = 1'b1;
      end else if (we0_s[r] || we1_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Register array update; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (we1_s[r]) begin
          regs_r[r] <= rf.wdata1;
        end else if (we0_s[r]) begin
          regs_r[r] <= rf.wdata0;
        end else begin
          regs_r[r] <= regs_r[r];
        end
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rf.busy_vec = busy_r;

  // Array lookup for both read ports, {busy, data}; address 0 reads as all zero.
  always_comb begin
    rd1_s = {(XLEN+1){1'b0}};
    rd2_s = {(XLEN+1){1'b0}};
    if (rf.rs1 != {AW{1'b0}}) begin
      rd1_s = {busy_r[rf.rs1], regs_r[rf.rs1]};
    end else begin
      rd1_s = {(XLEN+1){1'b0}};
    end
    if (rf.rs2 != {AW{1'b0}}) begin
      rd2_s = {busy_r[rf.rs2], regs_r[rf.rs2]};
    end else begin
      rd2_s = {(XLEN+1){1'b0}};
    end
  end

  // Drive the read ports, forwarding in-flight writes when the bypass build is selected.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    {rf.busy1, rf.rdata1} = fwd_read(rf.rs1, rd1_s, reset_n, rf.wen1, rf.waddr1, rf.wdata1,
                                     rf.wen0, rf.waddr0, rf.wdata0);
    {rf.busy2, rf.rdata2} = fwd_read(rf.rs2, rd2_s, reset_n, rf.wen1, rf.waddr1, rf.wdata1,
                                     rf.wen0, rf.waddr0, rf.wdata0);
`else
    {rf.busy1, rf.rdata1} = rd1_s;
    {rf.busy2, rf.rdata2} = rd2_s;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp; expectations adapt to the REGFILE_BYPASS_EN build.
`timescale 1ns/1ps
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_B1  = 2;
  localparam int SEL_B2  = 3;
  localparam int SEL_BV  = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t exp_q[$];
  event smp_ev;
  int   pass_cnt;
  int   total_cnt;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) rf ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rf      (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // Monitor: on each sample request, pop every queued expectation and compare.
  initial begin
    exp_t        e;
    logic [31:0] act;
    pass_cnt  = 0;
    total_cnt = 0;
    forever begin
      @(smp_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.sel)
          SEL_RD1: act = rf.rdata1;
          SEL_RD2: act = rf.rdata2;
          SEL_B1:  act = {31'd0, rf.busy1};
          SEL_B2:  act = {31'd0, rf.busy2};
          SEL_BV:  act = rf.busy_vec;
          default: act = 32'hxxxxxxxx;
        endcase
        total_cnt++;
        if (act === e.exp) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] v, input string name);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic smp();
    -> smp_ev;
    #2;
  endtask

  task automatic idle();
    rf.rs1 = 5'd0;      rf.rs2 = 5'd0;
    rf.wen0 = 1'b0;     rf.waddr0 = 5'd0; rf.wdata0 = 32'd0;
    rf.wen1 = 1'b0;     rf.waddr1 = 5'd0; rf.wdata1 = 32'd0;
    rf.issue_en = 1'b0; rf.issue_rd = 5'd0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    rf.wen0 = 1'b1; rf.waddr0 = a; rf.wdata0 = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    rf.wen1 = 1'b1; rf.waddr1 = a; rf.wdata1 = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    rf.issue_en = 1'b1; rf.issue_rd = rd;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    expect_val(SEL_BV, 32'h0, "reset_busy_vec");
    expect_val(SEL_RD2, 32'h0, "reset_rd2");
    smp();
    reset_n = 1'b1;

    // Basic write / read
    @(negedge clk); idle(); wr0(5'd3, 32'h12345678); rf.rs1 = 5'd3;
    expect_val(SEL_RD1, BYP ? 32'h12345678 : 32'h0, "wr_same_cycle_rd1");
    smp();
    @(negedge clk); idle(); rf.rs1 = 5'd3; rf.rs2 = 5'd0;
    expect_val(SEL_RD1, 32'h12345678, "basic_rd1");
    expect_val(SEL_RD2, 32'h0, "basic_rd2_x0");
    smp();

    // x0 protection
    @(negedge clk); idle(); wr1(5'd0, 32'hFFFFFFFF); issue(5'd0);
    expect_val(SEL_RD1, 32'h0, "x0_rd_same");
    smp();
    @(negedge clk); idle();
    expect_val(SEL_RD1, 32'h0, "x0_rd");
    expect_val(SEL_B1, 32'h0, "x0_busy1");
    expect_val(SEL_BV, 32'h0, "x0_busy_vec");
    smp();

    // Write collision, load port wins
    @(negedge clk); idle(); wr0(5'd9, 32'hAAAA0000); wr1(5'd9, 32'h0000BBBB); rf.rs1 = 5'd9;
    expect_val(SEL_RD1, BYP ? 32'h0000BBBB : 32'h0, "coll_same_rd1");
    smp();
    @(negedge clk); idle(); rf.rs1 = 5'd9; rf.rs2 = 5'd3;
    expect_val(SEL_RD1, 32'h0000BBBB, "coll_rd1");
    expect_val(SEL_RD2, 32'h12345678, "x3_hold_rd2");
    smp();

    // Scoreboard on x4, cycles 0..6
    @(negedge clk); idle(); issue(5'd4); rf.rs1 = 5'd4;
    expect_val(SEL_B1, 32'h0, "sb_c0_busy1");
    expect_val(SEL_BV, 32'h0, "sb_c0_busy_vec");
    smp();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); idle(); rf.rs1 = 5'd4;
      expect_val(SEL_B1, 32'h1, "sb_c12_busy1");
      expect_val(SEL_BV, 32'h10, "sb_c12_busy_vec");
      smp();
    end
    @(negedge clk); idle(); wr0(5'd4, 32'h00000044); issue(5'd4); rf.rs1 = 5'd4;
    expect_val(SEL_B1, BYP ? 32'h0 : 32'h1, "sb_c3_busy1");
    expect_val(SEL_BV, 32'h10, "sb_c3_busy_vec");
    smp();
    @(negedge clk); idle(); rf.rs1 = 5'd4;
    expect_val(SEL_B1, 32'h1, "sb_c4_reissue_busy1");
    expect_val(SEL_BV, 32'h10, "sb_c4_busy_vec");
    expect_val(SEL_RD1, 32'h00000044, "sb_c4_rd1");
    smp();
    @(negedge clk); idle(); wr0(5'd4, 32'h00000055); rf.rs1 = 5'd4;
    expect_val(SEL_B1, BYP ? 32'h0 : 32'h1, "sb_c5_busy1");
    expect_val(SEL_BV, 32'h10, "sb_c5_busy_vec");
    smp();
    @(negedge clk); idle(); rf.rs1 = 5'd4;
    expect_val(SEL_B1, 32'h0, "sb_c6_busy1");
    expect_val(SEL_BV, 32'h0, "sb_c6_busy_vec");
    expect_val(SEL_RD1, 32'h00000055, "sb_c6_rd1");
    smp();

    // Bypass behaviour on x6 (old value 0x11111111, busy via issue)
    @(negedge clk); idle(); wr0(5'd6, 32'h11111111); issue(5'd6);
    @(negedge clk); idle(); wr1(5'd6, 32'hCAFEF00D); rf.rs2 = 5'd6;
    expect_val(SEL_RD2, BYP ? 32'hCAFEF00D : 32'h11111111, "byp_rd2");
    expect_val(SEL_B2, BYP ? 32'h0 : 32'h1, "byp_busy2");
    smp();
    @(negedge clk); idle(); rf.rs2 = 5'd6;
    expect_val(SEL_RD2, 32'hCAFEF00D, "byp_rd2_next");
    expect_val(SEL_B2, 32'h0, "byp_busy2_next");
    expect_val(SEL_BV, 32'h0, "byp_busy_vec_next");
    smp();

    // Asynchronous reset mid-run
    @(negedge clk); idle(); wr0(5'd5, 32'hDEADBEEF); issue(5'd7);
    @(negedge clk); idle(); rf.rs1 = 5'd5; rf.rs2 = 5'd7;
    expect_val(SEL_RD1, 32'hDEADBEEF, "pre_rst_rd1");
    expect_val(SEL_BV, 32'h80, "pre_rst_busy_vec");
    expect_val(SEL_B2, 32'h1, "pre_rst_busy2");
    smp();
    reset_n = 1'b0;
    expect_val(SEL_RD1, 32'h0, "rst_async_rd1");
    expect_val(SEL_BV, 32'h0, "rst_async_busy_vec");
    expect_val(SEL_B2, 32'h0, "rst_async_busy2");
    smp();
    @(negedge clk); idle(); wr0(5'd5, 32'h77777777); issue(5'd8); rf.rs1 = 5'd5;
    expect_val(SEL_RD1, 32'h0, "rst_wr_ignored_same");
    smp();
    @(negedge clk); idle(); reset_n = 1'b1; rf.rs1 = 5'd5; rf.rs2 = 5'd8;
    expect_val(SEL_RD1, 32'h0, "rst_wr_ignored");
    expect_val(SEL_B2, 32'h0, "rst_issue_ignored");
    expect_val(SEL_BV, 32'h0, "rst_busy_vec_after");
    smp();
    @(negedge clk); idle(); wr1(5'd5, 32'h5A5A5A5A);
    @(negedge clk); idle(); rf.rs1 = 5'd5;
    expect_val(SEL_RD1, 32'h5A5A5A5A, "post_rst_wr_rd1");
    smp();

    #3;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
